// File: rtl/comp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, result bundle, default chunk size.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic g;
    logic l;
    logic e;
  } cmp_res_t;

  localparam int DEF_CHUNK = 2;

endpackage

// File: rtl/comp_chunk.sv
// Purely combinational CHUNK-bit unsigned magnitude compare.
module comp_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             g,
  output logic             l,
  output logic             e
);

  assign g = (a > b);
  assign l = (a < b);
  assign e = (a == b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per clock from the MSB down.
// Optional build macro COMP_EARLY_EXIT_EN: finish on the first differing chunk.
module seq_mag_comparator
  import comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] Q,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             G,
  output logic             L,
  output logic             E,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and the result holds until taken.

  cmp_state_t       state, state_nxt;
  logic [WIDTH-1:0] p_reg, q_reg;
  logic [IDX_W-1:0] idx;
  logic             seen_g, seen_l;
  cmp_res_t         res;
  logic [CHUNK-1:0] p_slice, q_slice;
  logic             c_g, c_l, c_e;
  logic             last_chunk;
  logic             fin_g, fin_l, fin_e;

  assign p_slice = p_reg[idx*CHUNK +: CHUNK];
  assign q_slice = q_reg[idx*CHUNK +: CHUNK];

  comp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a (p_slice),
    .b (q_slice),
    .g (c_g),
    .l (c_l),
    .e (c_e)
  );

`ifdef COMP_EARLY_EXIT_EN
  assign last_chunk = (idx == '0) || c_g || c_l;
`else
  assign last_chunk = (idx == '0);
`endif

  // The first difference seen (most significant) decides; later chunks cannot override it.
  assign fin_g = seen_g | (~seen_l & c_g);
  assign fin_l = seen_l | (~seen_g & c_l);
  assign fin_e = ~seen_g & ~seen_l & c_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = RUN;
      RUN:     if (last_chunk) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg  <= '0;
      q_reg  <= '0;
      idx    <= '0;
      seen_g <= 1'b0;
      seen_l <= 1'b0;
      res    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Flipping the sign bits maps two's-complement order onto unsigned order.
            p_reg  <= {P[WIDTH-1] ^ signed_mode, P[WIDTH-2:0]};
            q_reg  <= {Q[WIDTH-1] ^ signed_mode, Q[WIDTH-2:0]};
            idx    <= IDX_W'(NCHUNK - 1);
            seen_g <= 1'b0;
            seen_l <= 1'b0;
          end
        end
        RUN: begin
          if (last_chunk) begin
            res <= '{g: fin_g, l: fin_l, e: fin_e};
          end else begin
            idx <= idx - 1'b1;
            if (!seen_g && !seen_l) begin
              seen_g <= c_g;
              seen_l <= c_l;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign G         = res.g;
  assign L         = res.l;
  assign E         = res.e;
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed, table-driven bench for seq_mag_comparator (WIDTH=16, CHUNK=2) plus multi-cycle corner sequences.
module tb_seq_mag_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] P, Q;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic        G, L, E;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [15:0] p;
    logic [15:0] q;
    logic        sm;
    logic [2:0]  gle;
    int          lat_early;
  } vec_t;

  vec_t vecs[12];

  seq_mag_comparator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .P           (P),
    .Q           (Q),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .G           (G),
    .L           (L),
    .E           (E),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard check ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=%0h req=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int exp_latency(input int lat_early);
`ifdef COMP_EARLY_EXIT_EN
    return lat_early;
`else
    return (lat_early > 0) ? 8 : 8;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Issue one op, wait for out_valid, score latency and result. Result left pending (not consumed).
  task automatic issue_and_wait(input logic [15:0] p, input logic [15:0] q, input logic sm,
                                input logic [2:0] gle, input int lat_req, input string name);
    int lat;
    logic [2:0] exp_gle;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    P = p; Q = q; signed_mode = sm; in_valid = 1'b1;
    exp_q.push_back(gle);
    @(posedge clk);
    #1 in_valid = 1'b0;
    P = $urandom_range(0, 16'hFFFF);
    Q = $urandom_range(0, 16'hFFFF);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, lat_req);
    exp_gle = exp_q.pop_front();
    check({name, "_gle"}, {G, L, E}, exp_gle);
  endtask

  task automatic consume(input string name);
    logic [2:0] held;
    held = {G, L, E};
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({name, "_ov_drop"}, {out_valid, in_ready}, 2'b01);
    check({name, "_gle_held"}, {G, L, E}, held);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vecs[0]  = '{16'h1234, 16'h1234, 1'b0, 3'b001, 8};
    vecs[1]  = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 1};
    vecs[2]  = '{16'h8000, 16'h7FFF, 1'b1, 3'b010, 1};
    vecs[3]  = '{16'h0001, 16'h0002, 1'b0, 3'b010, 8};
    vecs[4]  = '{16'hFFFF, 16'h0000, 1'b1, 3'b010, 1};
    vecs[5]  = '{16'h00F0, 16'h0F00, 1'b0, 3'b010, 3};
    vecs[6]  = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 1};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b1, 3'b001, 8};
    vecs[8]  = '{16'hFFFE, 16'hFFFF, 1'b0, 3'b010, 8};
    vecs[9]  = '{16'hC000, 16'h4000, 1'b1, 3'b010, 1};
    vecs[10] = '{16'h0003, 16'h0001, 1'b0, 3'b100, 8};
    vecs[11] = '{16'h1000, 16'h0FFF, 1'b0, 3'b100, 2};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    P = '0; Q = '0; signed_mode = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hold_outputs", {out_valid, G, L, E, dbg_state}, 6'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release", {in_ready, out_valid, G, L, E}, 5'b10000);
    check("rst_state_idle", dbg_state, 2'd0);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      issue_and_wait(vecs[i].p, vecs[i].q, vecs[i].sm, vecs[i].gle,
                     exp_latency(vecs[i].lat_early), $sformatf("vec%0d", i));
      consume($sformatf("vec%0d", i));
    end

    // Back-pressure: result held for 5 clocks, in_valid pulses ignored
    issue_and_wait(16'h8000, 16'h7FFF, 1'b1, 3'b010, 1 * 0 + exp_latency(1), "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 1 || i == 3);
      P = 16'h0000; Q = 16'hFFFF; signed_mode = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", i), {out_valid, in_ready, G, L, E, dbg_state},
            {1'b1, 1'b0, 3'b010, 2'd2});
    end
    in_valid = 1'b0;
    consume("bp");
    // The ignored pulses must not have started an operation; out_ready is ignored when idle
    out_ready = 1'b1;
    begin
      int spurious = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        if (out_valid || dbg_state != 2'd0) spurious++;
      end
      check("bp_no_spurious_op", spurious, 0);
    end
    out_ready = 1'b0;

    // Reset in the 4th RUN clock of an equal compare
    @(negedge clk);
    P = 16'h5555; Q = 16'h5555; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_run_state", dbg_state, 2'd1);
    rst_n = 1'b0;
    #1;
    check("mid_run_reset", {dbg_state, in_ready, out_valid, G, L, E}, {2'd0, 5'b10000});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen_ov = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen_ov++;
      end
      check("mid_run_discarded", seen_ov, 0);
    end
    issue_and_wait(16'h00F0, 16'h0F00, 1'b0, 3'b010, exp_latency(3), "post_rst");
    consume("post_rst");

    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
